rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the ALU/execute path and the load/store unit.
- Arbitrates with round-robin, one write per cycle.
- Registers the winning write, so the register file sees a clean, one-cycle-delayed write strobe.
- Counts contention cycles for performance debug.

Parameters:
- XLEN, 32, data width of the register file write port.
- AW, 5, register address width (32 architectural registers).
- CW, 16, width of the saturating contention counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- alu_valid  input  1  ALU has a writeback pending.
- alu_ready  output  1  ALU writeback accepted this cycle.
- alu_rd  input  AW  ALU destination register.
- alu_data  input  XLEN  ALU result.
- lsu_valid  input  1  LSU has a writeback pending.
- lsu_ready  output  1  LSU writeback accepted this cycle.
- lsu_rd  input  AW  LSU destination register.
- lsu_data  input  XLEN  load result.
- rf_we  output  1  write enable to the register file.
- rf_rd  output  AW  write address to the register file.
- rf_data  output  XLEN  write data to the register file.
- last_grant  output  1  0 = ALU won the last transfer, 1 = LSU won.
- conflict_cnt  output  CW  number of cycles in which both sources were valid.

Behaviour:
- Reset (rst=1 at a clk edge): rf_we=0, rf_rd=0, rf_data=0, last_grant=1, conflict_cnt=0.
- While rst=1: alu_ready=0 and lsu_ready=0 combinationally; no transfer occurs.
- Grant logic is combinational from the valids and last_grant:
  - Only alu_valid=1: grant ALU.
  - Only lsu_valid=1: grant LSU.
  - Both valid: grant the source that is not last_grant.
  - Neither valid: no grant.
- Ready outputs: alu_ready = grant_alu & ~rst; lsu_ready = grant_lsu & ~rst. At most one ready is high in any cycle.
- Transfer: occurs when valid & ready. A source that sees valid=1 and ready=0 must hold rd and data stable and keep valid high. It is never dropped; it wins on a later cycle.
- Output register, latency 1 cycle:
  - On a transfer in cycle N, cycle N+1 shows rf_rd = winner rd and rf_data = winner data.
  - rf_we in N+1 is 1 only if winner rd != 0. An x0 write is consumed (ready=1) but never strobed, and rf_rd/rf_data still update.
  - With no transfer in cycle N, rf_we=0 in N+1 and rf_rd/rf_data hold their previous values.
- last_grant: updated on every transfer to the winner index (0 ALU, 1 LSU); unchanged when there is no transfer.
  - Consequence: a lone source winning repeatedly makes the other source win the next contention.
- conflict_cnt: increments by 1 in any non-reset cycle with alu_valid=1 and lsu_valid=1. It saturates at all-ones (2^CW-1) and never wraps.
- Fairness bound: under continuous contention, grants strictly alternate, so each source waits at most 1 cycle.
- Reset mid-operation: a transfer accepted in the cycle before rst rises is discarded. rf_we is 0 in every cycle following a reset edge. Sources must re-present after reset.
- Same rd from both sources on consecutive cycles: both writes issue in grant order, the later overwrites. No merging or reordering.
- The RF reads after writes within its own clock edge. This block provides no bypass; forwarding is the pipeline's responsibility.

Test Plan:
- Reset: hold rst 2 cycles with alu_valid=lsu_valid=1 -> both readys 0; after release rf_we=0, last_grant=1, conflict_cnt=0.
- Lone ALU: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF; following cycle rf_we=0.
- Contention after reset: both valid (ALU rd=3 data=0x11, LSU rd=4 data=0x22), held until accepted:
  - ALU is granted first, then LSU.
  - rf writes (3,0x11) then (4,0x22) on consecutive cycles.
  - conflict_cnt=1.
- Sustained contention: both valid for 6 cycles -> grants alternate ALU, LSU, ALU, LSU, ALU, LSU; conflict_cnt=6; no gap cycles on rf_we.
- x0 write: lsu_valid=1, rd=0, data=0xFFFFFFFF -> lsu_ready=1; next cycle rf_we=0, rf_rd=0, rf_data=0xFFFFFFFF; last_grant=1.
- Saturation and mid-op reset:
  - Run with CW=4 and contention for 20 cycles -> conflict_cnt holds at 15.
  - Assert rst the cycle after a transfer -> rf_we stays 0; the counter clears to 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register file write port between the ALU and LSU writeback paths.
// The winning write is registered. A saturating counter records the cycles in which both sources contend.
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_data,
    output logic            last_grant,
    output logic [CW-1:0]   conflict_cnt
);

    logic            grant_alu;
    logic            grant_lsu;
    logic            xfer;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;
    logic            we_q;

    always_comb begin
        grant_alu = alu_valid & (~lsu_valid | last_grant);
        grant_lsu = lsu_valid & (~alu_valid | ~last_grant);
        alu_ready = grant_alu & ~rst;
        lsu_ready = grant_lsu & ~rst;
        xfer      = alu_ready | lsu_ready;
        win_rd    = lsu_ready ? lsu_rd   : alu_rd;
        win_data  = lsu_ready ? lsu_data : alu_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q         <= 1'b0;
            rf_rd        <= '0;
            rf_data      <= '0;
            last_grant   <= 1'b1;
            conflict_cnt <= '0;
        end else begin
            // Writes to x0 are consumed but never strobed.
            we_q <= xfer && (win_rd != '0);
            if (xfer) begin
                rf_rd      <= win_rd;
                rf_data    <= win_data;
                last_grant <= lsu_ready;
            end
            if (alu_valid && lsu_valid && !(&conflict_cnt))
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    // A write accepted just before reset rises must never reach the register file.
    assign rf_we = we_q & ~rst;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard testbench for rf_wb_arbiter: each accepted write is queued when driven and compared one cycle later.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid;
    logic        alu_ready, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, rf_rd;
    logic [31:0] alu_data, lsu_data, rf_data;
    logic        rf_we, last_grant;
    logic [3:0]  conflict_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t        sb[$];
    wr_t        e;
    logic       m_last;
    logic [3:0] m_cnt;
    logic       ea, el;

    rf_wb_arbiter #(.XLEN(32), .AW(5), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data),
        .last_grant   (last_grant),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model step: expected grants for the current inputs; queues the resulting write.
    task automatic predict(output logic pa, output logic pl);
        pa = alu_valid & (~lsu_valid | m_last) & ~rst;
        pl = lsu_valid & (~alu_valid | ~m_last) & ~rst;
        if (!rst && alu_valid && lsu_valid && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        if (pa) begin
            sb.push_back('{we: (alu_rd != 5'd0), rd: alu_rd, data: alu_data});
            m_last = 1'b0;
        end else if (pl) begin
            sb.push_back('{we: (lsu_rd != 5'd0), rd: lsu_rd, data: lsu_data});
            m_last = 1'b1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        tick; tick;
        rst = 1'b0;
        m_last = 1'b1; m_cnt = 4'd0; sb.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_rd = 5'd1; alu_data = 32'h1; lsu_rd = 5'd2; lsu_data = 32'h2;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready cyc %0d got alu=%b lsu=%b want 0 0", i, alu_ready, lsu_ready);
            end
            tick;
        end
        rst = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
        m_last = 1'b1; m_cnt = 4'd0; sb.delete();
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rf got we=%b rd=%0d data=%h want 0 0 0", rf_we, rf_rd, rf_data);
        end
        checks++;
        if (last_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_last_grant got %b want 1", last_grant);
        end
        checks++;
        if (conflict_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", conflict_cnt);
        end
        tick;
    endtask

    task automatic test_lone_alu;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        predict(ea, el);
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("FAIL lone_alu_ready got alu=%b lsu=%b want 1 0", alu_ready, lsu_ready);
        end
        tick;
        alu_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL lone_alu_sb got empty want entry");
        end else begin
            e = sb.pop_front();
            if (rf_we !== e.we || rf_rd !== e.rd || rf_data !== e.data) begin
                errors++;
                $display("FAIL lone_alu_write got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h",
                         rf_we, rf_rd, rf_data, e.we, e.rd, e.data);
            end
        end
        checks++;
        if (last_grant !== m_last) begin
            errors++;
            $display("FAIL lone_alu_last_grant got %b want %b", last_grant, m_last);
        end
        tick;
        checks++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lone_alu_idle got we=%b rd=%0d data=%h want 0 5 deadbeef", rf_we, rf_rd, rf_data);
        end
    endtask

    task automatic test_contention;
        do_reset;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        for (int i = 0; i < 2; i++) begin
            #1;
            predict(ea, el);
            checks++;
            if (alu_ready !== (i == 0) || lsu_ready !== (i == 1)) begin
                errors++;
                $display("FAIL contention_grant cyc %0d got alu=%b lsu=%b want %b %b",
                         i, alu_ready, lsu_ready, i == 0, i == 1);
            end
            tick;
            if (ea) alu_valid = 1'b0;
            if (el) lsu_valid = 1'b0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL contention_sb cyc %0d got empty want entry", i);
            end else begin
                e = sb.pop_front();
                if (rf_we !== e.we || rf_rd !== e.rd || rf_data !== e.data) begin
                    errors++;
                    $display("FAIL contention_write cyc %0d got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h",
                             i, rf_we, rf_rd, rf_data, e.we, e.rd, e.data);
                end
            end
        end
        checks++;
        if (conflict_cnt !== 4'd1) begin
            errors++;
            $display("FAIL contention_cnt got %0d want 1", conflict_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int na = 0;
        int nl = 0;
        do_reset;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_rd = 5'd1;  alu_data = 32'hA000_0000;
        lsu_rd = 5'd10; lsu_data = 32'hB000_0000;
        for (int i = 0; i < 6; i++) begin
            #1;
            predict(ea, el);
            checks++;
            if (alu_ready !== (i % 2 == 0) || lsu_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL b2b_grant cyc %0d got alu=%b lsu=%b want %b %b",
                         i, alu_ready, lsu_ready, i % 2 == 0, i % 2 == 1);
            end
            tick;
            // Only the accepted source moves on to a new write; the loser holds.
            if (ea) begin na++; alu_rd = 5'(1 + na);  alu_data = 32'hA000_0000 + 32'(na); end
            if (el) begin nl++; lsu_rd = 5'(10 + nl); lsu_data = 32'hB000_0000 + 32'(nl); end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL b2b_sb cyc %0d got empty want entry", i);
            end else begin
                e = sb.pop_front();
                if (rf_we !== 1'b1 || rf_rd !== e.rd || rf_data !== e.data) begin
                    errors++;
                    $display("FAIL b2b_write cyc %0d got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                             i, rf_we, rf_rd, rf_data, e.rd, e.data);
                end
            end
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        checks++;
        if (conflict_cnt !== 4'd6) begin
            errors++;
            $display("FAIL b2b_cnt got %0d want 6", conflict_cnt);
        end
    endtask

    task automatic test_x0_write;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFFFF_FFFF;
        #1;
        predict(ea, el);
        checks++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_ready got alu=%b lsu=%b want 0 1", alu_ready, lsu_ready);
        end
        tick;
        lsu_valid = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL x0_sb got empty want entry");
        end else begin
            e = sb.pop_front();
            if (rf_we !== e.we || rf_rd !== e.rd || rf_data !== e.data) begin
                errors++;
                $display("FAIL x0_write got we=%b rd=%0d data=%h want we=%b rd=%0d data=%h",
                         rf_we, rf_rd, rf_data, e.we, e.rd, e.data);
            end
        end
        checks++;
        if (last_grant !== 1'b1) begin
            errors++;
            $display("FAIL x0_last_grant got %b want 1", last_grant);
        end
    endtask

    task automatic test_saturation_reset;
        do_reset;
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
        for (int i = 0; i < 20; i++) begin
            #1;
            predict(ea, el);
            tick;
            if (sb.size() != 0) e = sb.pop_front();
            checks++;
            if (conflict_cnt !== m_cnt) begin
                errors++;
                $display("FAIL sat_cnt cyc %0d got %0d want %0d", i, conflict_cnt, m_cnt);
            end
        end
        checks++;
        if (conflict_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_final got %0d want 15", conflict_cnt);
        end
        lsu_valid = 1'b0; alu_rd = 5'd7; alu_data = 32'h77;
        #1;
        predict(ea, el);
        tick;
        alu_valid = 1'b0; rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_discard got we=%b want 0", rf_we);
        end
        tick;
        checks++;
        if (rf_we !== 1'b0 || conflict_cnt !== 4'd0 || last_grant !== 1'b1 || rf_rd !== 5'd0) begin
            errors++;
            $display("FAIL midrst_state got we=%b cnt=%0d lg=%b rd=%0d want 0 0 1 0",
                     rf_we, conflict_cnt, last_grant, rf_rd);
        end
        rst = 1'b0; m_last = 1'b1; m_cnt = 4'd0;
        tick;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after got we=%b want 0", rf_we);
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
        m_last = 1'b1; m_cnt = 4'd0;
        tick;
        test_reset;
        test_lone_alu;
        test_contention;
        test_back_to_back;
        test_x0_write;
        test_saturation_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
